obi_mem_responder: RTL and testbench

- Memory-side responder for the core's req/gnt/rvalid data bus; the far end of what the memory arbiter drives.
- Accepts one address-phase transaction per grant, with optional wait states before grant.
- Holds a word-addressed SRAM with byte-enable writes and returns exactly one in-order response per granted transaction after a fixed latency.
- Serves as the main-memory model behind the arbiter, and later as the on-chip RAM.

---
 rtl/mem_resp_pkg.sv | 19 +
 rtl/obi_mem_responder_if.sv | 24 ++
 rtl/mem_resp_delay_line.sv | 30 +++
 rtl/obi_mem_responder.sv | 128 ++++++++++++
 tb/tb_obi_mem_responder.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and bounds for the OBI memory responder.
package mem_resp_pkg;

    localparam int unsigned LATENCY_MIN  = 1;
    localparam int unsigned LATENCY_MAX  = 8;
    localparam int unsigned GNT_WAIT_MAX = 15;
    localparam int unsigned CNT_W        = $clog2(GNT_WAIT_MAX + 1);

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_WAIT = 1'b1;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] data;
    } resp_t;

endpackage

// File: rtl/obi_mem_responder_if.sv
// req/gnt/rvalid data bus between an initiator and the memory responder.
interface obi_mem_responder_if;

    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic [31:0] rdata;
    logic        rvalid;
    logic        err;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rdata, rvalid, err
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rdata, rvalid, err
    );

endinterface

// File: rtl/mem_resp_delay_line.sv
// Fixed-depth response pipe; every stage is cleared on reset so nothing in flight survives.
module mem_resp_delay_line
    import mem_resp_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic  clk,
    input  logic  rst,
    input  resp_t din,
    output resp_t dout
);

    resp_t stage [LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < LATENCY; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[LATENCY-1];

endmodule

// File: rtl/obi_mem_responder.sv
// Word-addressed SRAM responder: optional grant wait states, byte-enable writes,
// and one in-order response per grant after a fixed latency.
module obi_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned LATENCY   = 1,
    parameter int unsigned GNT_WAIT  = 0
) (
    input logic                clk,
    input logic                rst,
    obi_mem_responder_if.slave bus
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(DEPTH * 4);

    if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
        $error("obi_mem_responder: LATENCY out of range");
    end
    if (GNT_WAIT > GNT_WAIT_MAX) begin : g_bad_gnt_wait
        $error("obi_mem_responder: GNT_WAIT out of range");
    end

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             gnt_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Grant FSM: each request pays GNT_WAIT cycles; a dropped request abandons the wait.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        gnt_c     = 1'b0;
        if (GNT_WAIT == 0) begin
            state_nxt = ST_IDLE;
            gnt_c     = bus.req;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req) begin
                        cnt_nxt   = CNT_W'(GNT_WAIT);
                        state_nxt = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt_nxt = cnt - CNT_W'(1);
                    if (!bus.req) begin
                        cnt_nxt   = '0;
                        state_nxt = ST_IDLE;
                    end else if (cnt == CNT_W'(1)) begin
                        gnt_c     = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign bus.gnt = gnt_c;

    logic [31:0]   offset;
    logic          in_range;
    logic [AW-1:0] idx;
    logic          txn;

    assign offset   = bus.addr - BASE_ADDR;
    assign in_range = (bus.addr >= BASE_ADDR) && (offset < SPAN);
    assign idx      = offset[AW+1:2];
    assign txn      = bus.req & gnt_c;

    logic [31:0] mem [DEPTH];

    // Byte-enable merge happens in place; unselected lanes keep their old contents.
    always_ff @(posedge clk) begin
        if (txn && bus.we && in_range) begin
            for (int n = 0; n < 4; n++) begin
                if (bus.be[n]) begin
                    mem[idx][8*n +: 8] <= bus.wdata[8*n +: 8];
                end
            end
        end
    end

    resp_t resp_in;
    resp_t resp_out;

    always_comb begin
        resp_in = '0;
        if (txn) begin
            resp_in.valid = 1'b1;
            resp_in.err   = !in_range;
            if (!bus.we && in_range) begin
                resp_in.data = mem[idx];
            end
        end
    end

    mem_resp_delay_line #(
        .LATENCY (LATENCY)
    ) u_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (resp_in),
        .dout (resp_out)
    );

    assign bus.rvalid = resp_out.valid;
    assign bus.rdata  = resp_out.data;
    assign bus.err    = resp_out.err;

endmodule

// File: tb/tb_obi_mem_responder.sv
// Scoreboard bench for obi_mem_responder across three parameter sets sharing one stimulus bus.
module tb_obi_mem_responder;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rst_c;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          sel;
    int          cyc = 0;
    int          assert_cnt = 0;
    int          fail_cnt = 0;
    exp_t        exp_q [$];

    logic        gnt_m;
    logic        rvalid_m;
    logic [31:0] rdata_m;
    logic        err_m;
    int          lat_m;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    obi_mem_responder_if ia ();
    obi_mem_responder_if ib ();
    obi_mem_responder_if ic ();

    assign ia.req = req && (sel == 0);
    assign ib.req = req && (sel == 1);
    assign ic.req = req && (sel == 2);
    assign ia.addr = addr;  assign ib.addr = addr;  assign ic.addr = addr;
    assign ia.we = we;      assign ib.we = we;      assign ic.we = we;
    assign ia.be = be;      assign ib.be = be;      assign ic.be = be;
    assign ia.wdata = wdata; assign ib.wdata = wdata; assign ic.wdata = wdata;

    obi_mem_responder #(.DEPTH(1024), .BASE_ADDR(32'h0), .LATENCY(1), .GNT_WAIT(0))
        dut_a (.clk(clk), .rst(rst), .bus(ia));
    obi_mem_responder #(.DEPTH(1024), .BASE_ADDR(32'h0), .LATENCY(2), .GNT_WAIT(2))
        dut_b (.clk(clk), .rst(rst), .bus(ib));
    obi_mem_responder #(.DEPTH(1024), .BASE_ADDR(32'h0), .LATENCY(3), .GNT_WAIT(0))
        dut_c (.clk(clk), .rst(rst_c), .bus(ic));

    always_comb begin
        case (sel)
            1: begin
                gnt_m = ib.gnt; rvalid_m = ib.rvalid; rdata_m = ib.rdata; err_m = ib.err; lat_m = 2;
            end
            2: begin
                gnt_m = ic.gnt; rvalid_m = ic.rvalid; rdata_m = ic.rdata; err_m = ic.err; lat_m = 3;
            end
            default: begin
                gnt_m = ia.gnt; rvalid_m = ia.rvalid; rdata_m = ia.rdata; err_m = ia.err; lat_m = 1;
            end
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assert_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] b);
        logic [31:0] r;
        r = o;
        for (int k = 0; k < 4; k++) begin
            if (b[k]) r[8*k +: 8] = n[8*k +: 8];
        end
        return r;
    endfunction

    // Present one transaction, wait (bounded) for its grant and queue its expected response.
    task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] b,
                         input logic [31:0] d, input logic [31:0] ed, input logic ee,
                         output int waited);
        int start;
        bit got;
        @(negedge clk);
        req = 1'b1; addr = a; we = w; be = b; wdata = d;
        start  = cyc;
        got    = 1'b0;
        waited = -1;
        for (int i = 0; i < 40 && !got; i++) begin
            #1;
            if (gnt_m) begin
                exp_q.push_back('{data: ed, err: ee, due: cyc + lat_m});
                waited = cyc - start;
                got    = 1'b1;
                @(posedge clk);
            end else begin
                @(negedge clk);
            end
        end
        if (!got) check_eq("gnt_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        req = 1'b0; we = 1'b0; be = 4'h0;
        repeat (n) @(negedge clk);
    endtask

    // Response monitor: pops the scoreboard on rvalid and checks data, error and arrival cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rvalid_m) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_rvalid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("rdata", rdata_m, e.data);
                check_eq("err", 32'(err_m), 32'(e.err));
                check_eq("rvalid_cycle", 32'(cyc), 32'(e.due));
            end
        end else begin
            check_eq("idle_rdata", rdata_m, 32'd0);
            check_eq("idle_err", 32'(err_m), 32'd0);
            if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                e = exp_q.pop_front();
                check_eq("missing_rvalid", 32'(cyc), 32'(e.due));
            end
        end
    end

    initial begin
        int          w;
        int          k;
        logic [31:0] mdl [16];
        logic [31:0] d;
        logic [3:0]  b;

        rst = 1'b1; rst_c = 1'b1; req = 1'b0; addr = '0; we = 1'b0; be = '0; wdata = '0; sel = 0;
        repeat (3) @(negedge clk);
        req = 1'b1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check_eq("rst_rvalid", 32'(rvalid_m), 32'd0);
            check_eq("rst_rdata", rdata_m, 32'd0);
            check_eq("rst_err", 32'(err_m), 32'd0);
        end
        req = 1'b0;
        sel = 0;
        #1;
        check_eq("rst_gnt", 32'(gnt_m), 32'd0);
        @(negedge clk);
        rst = 1'b0; rst_c = 1'b0;

        // Zero-wait, latency-1 responder: basic write/read, byte enables, out of range.
        issue(32'h10, 1'b1, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, w);
        check_eq("a_wait_wr", 32'(w), 32'd0);
        issue(32'h10, 1'b0, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0, w);
        check_eq("a_wait_rd", 32'(w), 32'd0);
        issue(32'h20, 1'b1, 4'hF, 32'h11223344, 32'h0, 1'b0, w);
        issue(32'h20, 1'b1, 4'b0100, 32'hAABBCCDD, 32'h0, 1'b0, w);
        issue(32'h20, 1'b0, 4'hF, 32'h0, 32'h11BB3344, 1'b0, w);
        issue(32'h0, 1'b1, 4'hF, 32'h0BADF00D, 32'h0, 1'b0, w);
        issue(32'hFFC, 1'b1, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0, w);
        issue(32'h1000, 1'b1, 4'hF, 32'h12345678, 32'h0, 1'b1, w);
        issue(32'h1000, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1, w);
        issue(32'hFFC, 1'b0, 4'hF, 32'h0, 32'hCAFEF00D, 1'b0, w);
        issue(32'h0, 1'b0, 4'hF, 32'h0, 32'h0BADF00D, 1'b0, w);
        issue(32'h13, 1'b1, 4'h0, 32'hFFFFFFFF, 32'h0, 1'b0, w);
        issue(32'h12, 1'b0, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0, w);
        idle(2);

        // Random byte-enable traffic against a word model.
        for (int i = 0; i < 16; i++) begin
            mdl[i] = $urandom;
            issue(32'h100 + 32'(4 * i), 1'b1, 4'hF, mdl[i], 32'h0, 1'b0, w);
        end
        for (int i = 0; i < 40; i++) begin
            k = int'($urandom_range(15));
            if ($urandom_range(1) == 1) begin
                d = $urandom;
                b = 4'($urandom);
                mdl[k] = merge(mdl[k], d, b);
                issue(32'h100 + 32'(4 * k), 1'b1, b, d, 32'h0, 1'b0, w);
            end else begin
                issue(32'h100 + 32'(4 * k), 1'b0, 4'hF, 32'h0, mdl[k], 1'b0, w);
            end
        end
        idle(6);

        // Two grant wait states, back-to-back held requests, abandoned request.
        sel = 1;
        issue(32'h20, 1'b1, 4'hF, 32'h5A5A5A5A, 32'h0, 1'b0, w);
        check_eq("b_wait_first", 32'(w), 32'd2);
        issue(32'h24, 1'b1, 4'hF, 32'hA5A5A5A5, 32'h0, 1'b0, w);
        check_eq("b_wait_second", 32'(w), 32'd2);
        idle(4);
        req = 1'b1; addr = 32'h20; we = 1'b0; be = 4'hF;
        #1;
        check_eq("b_abort_gnt0", 32'(gnt_m), 32'd0);
        @(negedge clk);
        req = 1'b0;
        #1;
        check_eq("b_abort_gnt1", 32'(gnt_m), 32'd0);
        issue(32'h20, 1'b0, 4'hF, 32'h0, 32'h5A5A5A5A, 1'b0, w);
        check_eq("b_wait_after_abort", 32'(w), 32'd2);
        issue(32'h24, 1'b0, 4'hF, 32'h0, 32'hA5A5A5A5, 1'b0, w);
        check_eq("b_wait_rd2", 32'(w), 32'd2);
        idle(6);

        // Latency 3: back-to-back reads, then reset with a read in flight.
        sel = 2;
        for (int i = 0; i < 4; i++) begin
            issue(32'(4 * i), 1'b1, 4'hF, 32'(i + 1), 32'h0, 1'b0, w);
        end
        idle(2);
        for (int i = 0; i < 4; i++) begin
            issue(32'(4 * i), 1'b0, 4'hF, 32'h0, 32'(i + 1), 1'b0, w);
            check_eq("c_wait_rd", 32'(w), 32'd0);
        end
        idle(6);
        issue(32'h8, 1'b0, 4'hF, 32'h0, 32'h3, 1'b0, w);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        rst_c = 1'b1;
        exp_q.delete();
        #1;
        check_eq("c_rst_gnt", 32'(gnt_m), 32'd0);
        check_eq("c_rst_rvalid", 32'(rvalid_m), 32'd0);
        check_eq("c_rst_rdata", rdata_m, 32'd0);
        check_eq("c_rst_err", 32'(err_m), 32'd0);
        @(negedge clk);
        rst_c = 1'b0;
        idle(8);
        issue(32'h4, 1'b0, 4'hF, 32'h0, 32'h2, 1'b0, w);
        idle(6);

        check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
